// File: rtl/commit_cu.sv
// Commit control unit: sequences retirement of the ROB head instruction and
// drives RF/store-buffer/CSR side effects, flushes, traps and FENCE/WFI waits.
package expipe_pkg;
  typedef enum logic [4:0] {
    COMM_NONE, COMM_INT_RF, COMM_INT_RF_FP, COMM_FP_RF, COMM_LOAD, COMM_LOAD_FP,
    COMM_STORE, COMM_BRANCH, COMM_JUMP, COMM_CSR, COMM_FENCE, COMM_ECALL,
    COMM_EBREAK, COMM_EXCEPT, COMM_MRET, COMM_WFI
  } comm_type_t;
endpackage

package csr_pkg;
  typedef enum logic [2:0] {
    CSR_OP_NONE, CSR_OP_CSRRW, CSR_OP_CSRRS, CSR_OP_CSRRC
  } csr_op_t;
endpackage

module commit_cu #(
  parameter int FLUSH_LEN = 1,
  parameter bit WFI_EN    = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  expipe_pkg::comm_type_t comm_type_i,
  input  csr_pkg::csr_op_t       csr_op_i,
  input  logic                   mispredict_i,
  input  logic                   sb_empty_i,
  input  logic                   irq_pending_i,
  input  logic                   csr_req_ready_i,
  output logic                   int_rf_we_o,
  output logic                   fp_rf_we_o,
  output logic                   fp_flags_we_o,
  output logic                   sb_commit_o,
  output logic                   csr_req_valid_o,
  output csr_pkg::csr_op_t       csr_req_op_o,
  output logic                   flush_o,
  output logic                   trap_o,
  output logic                   mret_o,
  output logic                   instret_o
);
  import expipe_pkg::*;
  import csr_pkg::*;

  localparam int CW = $clog2(FLUSH_LEN + 1);

  typedef enum logic [2:0] {COMMIT, WAIT_CSR, WAIT_FENCE, WFI_STALL, FLUSH} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  csr_op_t         csr_op_q, csr_op_d;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= COMMIT;
      cnt_q    <= '0;
      csr_op_q <= CSR_OP_NONE;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      csr_op_q <= csr_op_d;
    end
  end

  assign csr_req_op_o = csr_op_q;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statements can leave one unassigned and infer a latch.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    csr_op_d        = csr_op_q;
    ready_o         = 1'b0;
    int_rf_we_o     = 1'b0;
    fp_rf_we_o      = 1'b0;
    fp_flags_we_o   = 1'b0;
    sb_commit_o     = 1'b0;
    csr_req_valid_o = 1'b0;
    flush_o         = 1'b0;
    trap_o          = 1'b0;
    mret_o          = 1'b0;
    instret_o       = 1'b0;

    unique case (state_q)
      COMMIT: begin
        if (valid_i) begin
          ready_o   = 1'b1;
          instret_o = 1'b1;
          case (comm_type_i)
            COMM_INT_RF, COMM_LOAD: int_rf_we_o = 1'b1;
            COMM_INT_RF_FP: begin
              int_rf_we_o   = 1'b1;
              fp_flags_we_o = 1'b1;
            end
            COMM_FP_RF: begin
              fp_rf_we_o    = 1'b1;
              fp_flags_we_o = 1'b1;
            end
            COMM_LOAD_FP: fp_rf_we_o  = 1'b1;
            COMM_STORE:   sb_commit_o = 1'b1;
            COMM_BRANCH:  if (mispredict_i) state_d = FLUSH;
            COMM_JUMP: begin
              int_rf_we_o = 1'b1;
              if (mispredict_i) state_d = FLUSH;
            end
            COMM_CSR: begin
              ready_o   = 1'b0;
              instret_o = 1'b0;
              csr_op_d  = csr_op_i;
              state_d   = WAIT_CSR;
            end
            COMM_FENCE: begin
              if (sb_empty_i) begin
                state_d = FLUSH;
              end else begin
                ready_o   = 1'b0;
                instret_o = 1'b0;
                state_d   = WAIT_FENCE;
              end
            end
            COMM_MRET: begin
              mret_o  = 1'b1;
              state_d = FLUSH;
            end
            COMM_WFI: if (WFI_EN && !irq_pending_i) state_d = WFI_STALL;
            default: begin
              // ECALL/EBREAK/EXCEPT/NONE and any unknown encoding trap.
              instret_o = 1'b0;
              trap_o    = 1'b1;
              state_d   = FLUSH;
            end
          endcase
          if (state_d == FLUSH) cnt_d = CW'(FLUSH_LEN - 1);
        end
      end
      WAIT_CSR: begin
        csr_req_valid_o = 1'b1;
        if (csr_req_ready_i) begin
          ready_o     = 1'b1;
          int_rf_we_o = 1'b1;
          instret_o   = 1'b1;
          state_d     = FLUSH;
          cnt_d       = CW'(FLUSH_LEN - 1);
        end
      end
      WAIT_FENCE: begin
        if (sb_empty_i) begin
          ready_o   = 1'b1;
          instret_o = 1'b1;
          state_d   = FLUSH;
          cnt_d     = CW'(FLUSH_LEN - 1);
        end
      end
      WFI_STALL: if (irq_pending_i) state_d = COMMIT;
      FLUSH: begin
        flush_o = 1'b1;
        if (cnt_q == '0) state_d = COMMIT;
        else             cnt_d   = cnt_q - CW'(1);
      end
      default: state_d = COMMIT;
    endcase
  end
endmodule

// File: tb/tb_commit_cu.sv
// Directed bench for commit_cu: per-feature vector tables with hand-computed
// expected output vectors; a second instance covers WFI_EN=0.
module tb_commit_cu;
  import expipe_pkg::*;
  import csr_pkg::*;

  localparam logic [9:0] O_R = 10'h200, O_INT = 10'h100, O_FP = 10'h080,
                         O_FLG = 10'h040, O_SB = 10'h020, O_CV = 10'h010,
                         O_FL = 10'h008, O_T = 10'h004, O_M = 10'h002,
                         O_N = 10'h001;

  logic clk_i = 1'b0, rst_i = 1'b1;
  logic valid_i = 1'b0, mispredict_i = 1'b0, sb_empty_i = 1'b1;
  logic irq_pending_i = 1'b0, csr_req_ready_i = 1'b0;
  comm_type_t comm_type_i = COMM_NONE;
  csr_op_t    csr_op_i = CSR_OP_NONE;

  logic ready_o, int_rf_we_o, fp_rf_we_o, fp_flags_we_o, sb_commit_o;
  logic csr_req_valid_o, flush_o, trap_o, mret_o, instret_o;
  csr_op_t csr_req_op_o;
  logic b_ready, b_int, b_fp, b_flg, b_sb, b_cv, b_fl, b_t, b_m, b_n;
  csr_op_t b_op;

  int checks = 0, errors = 0;

  always #5 clk_i = ~clk_i;

  commit_cu #(.FLUSH_LEN(3), .WFI_EN(1'b1)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .comm_type_i(comm_type_i), .csr_op_i(csr_op_i), .mispredict_i(mispredict_i),
    .sb_empty_i(sb_empty_i), .irq_pending_i(irq_pending_i),
    .csr_req_ready_i(csr_req_ready_i), .int_rf_we_o(int_rf_we_o),
    .fp_rf_we_o(fp_rf_we_o), .fp_flags_we_o(fp_flags_we_o),
    .sb_commit_o(sb_commit_o), .csr_req_valid_o(csr_req_valid_o),
    .csr_req_op_o(csr_req_op_o), .flush_o(flush_o), .trap_o(trap_o),
    .mret_o(mret_o), .instret_o(instret_o)
  );

  commit_cu #(.FLUSH_LEN(1), .WFI_EN(1'b0)) dut_nowfi (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(b_ready),
    .comm_type_i(comm_type_i), .csr_op_i(csr_op_i), .mispredict_i(mispredict_i),
    .sb_empty_i(sb_empty_i), .irq_pending_i(irq_pending_i),
    .csr_req_ready_i(csr_req_ready_i), .int_rf_we_o(b_int),
    .fp_rf_we_o(b_fp), .fp_flags_we_o(b_flg), .sb_commit_o(b_sb),
    .csr_req_valid_o(b_cv), .csr_req_op_o(b_op), .flush_o(b_fl), .trap_o(b_t),
    .mret_o(b_m), .instret_o(b_n)
  );

  typedef struct {
    logic       v;
    comm_type_t t;
    logic       mp, sbe, irq, crdy;
    logic [9:0] exp;
    csr_op_t    op;
    logic       chk_b;
    logic [9:0] exp_b;
  } vec_t;

  function automatic vec_t mk(logic v, comm_type_t t, logic mp, logic sbe,
                              logic irq, logic crdy, logic [9:0] exp,
                              csr_op_t op = CSR_OP_NONE, logic chk_b = 1'b0,
                              logic [9:0] exp_b = '0);
    vec_t r;
    r.v = v; r.t = t; r.mp = mp; r.sbe = sbe; r.irq = irq; r.crdy = crdy;
    r.exp = exp; r.op = op; r.chk_b = chk_b; r.exp_b = exp_b;
    return r;
  endfunction

  function automatic logic [9:0] outs();
    return {ready_o, int_rf_we_o, fp_rf_we_o, fp_flags_we_o, sb_commit_o,
            csr_req_valid_o, flush_o, trap_o, mret_o, instret_o};
  endfunction

  function automatic logic [9:0] outs_b();
    return {b_ready, b_int, b_fp, b_flg, b_sb, b_cv, b_fl, b_t, b_m, b_n};
  endfunction

  task automatic apply(input vec_t x);
    valid_i = x.v; comm_type_i = x.t; mispredict_i = x.mp; sb_empty_i = x.sbe;
    irq_pending_i = x.irq; csr_req_ready_i = x.crdy; csr_op_i = x.op;
  endtask

  task automatic idle_inputs();
    valid_i = 1'b0; comm_type_i = COMM_NONE; mispredict_i = 1'b0;
    sb_empty_i = 1'b1; irq_pending_i = 1'b0; csr_req_ready_i = 1'b0;
    csr_op_i = CSR_OP_NONE;
  endtask

  task automatic test_reset();
    @(negedge clk_i);
    checks++;
    if (outs() !== 10'h0 || csr_req_op_o !== CSR_OP_NONE) begin
      errors++;
      $display("FAIL reset_initial: outs=%b op=%0d required outs=0 op=0", outs(), csr_req_op_o);
    end
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    valid_i = 1'b1; comm_type_i = COMM_FENCE; sb_empty_i = 1'b0;
    @(posedge clk_i); #1;
    @(negedge clk_i);
    checks++;
    if (outs() !== 10'h0) begin
      errors++;
      $display("FAIL reset_wait_fence: outs=%b required %b", outs(), 10'h0);
    end
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      checks++;
      if (outs() !== 10'h0) begin
        errors++;
        $display("FAIL reset_held[%0d]: outs=%b required %b", i, outs(), 10'h0);
      end
      @(posedge clk_i); #1;
    end
    rst_i = 1'b0;
    valid_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (outs() !== 10'h0) begin
      errors++;
      $display("FAIL reset_release_idle: outs=%b required %b", outs(), 10'h0);
    end
    @(posedge clk_i); #1;
    valid_i = 1'b1; comm_type_i = COMM_INT_RF;
    @(negedge clk_i);
    checks++;
    if (outs() !== (O_R | O_INT | O_N)) begin
      errors++;
      $display("FAIL reset_back_in_commit: outs=%b required %b", outs(), O_R | O_INT | O_N);
    end
    @(posedge clk_i); #1;
    idle_inputs();
    @(posedge clk_i); #1;
  endtask

  task automatic test_back_to_back();
    vec_t q[$];
    q.push_back(mk(1, COMM_INT_RF,    0, 1, 0, 0, O_R | O_INT | O_N));
    q.push_back(mk(1, COMM_STORE,     0, 1, 0, 0, O_R | O_SB | O_N));
    q.push_back(mk(1, COMM_LOAD_FP,   0, 1, 0, 0, O_R | O_FP | O_N));
    q.push_back(mk(1, COMM_LOAD,      0, 1, 0, 0, O_R | O_INT | O_N));
    q.push_back(mk(1, COMM_INT_RF_FP, 0, 1, 0, 0, O_R | O_INT | O_FLG | O_N));
    q.push_back(mk(1, COMM_FP_RF,     0, 1, 0, 0, O_R | O_FP | O_FLG | O_N));
    q.push_back(mk(0, COMM_INT_RF,    0, 1, 0, 0, 10'h0));
    foreach (q[i]) begin
      apply(q[i]);
      @(negedge clk_i);
      checks++;
      if (outs() !== q[i].exp) begin
        errors++;
        $display("FAIL back_to_back[%0d]: outs=%b required %b", i, outs(), q[i].exp);
      end
      @(posedge clk_i); #1;
    end
  endtask

  task automatic test_branch();
    vec_t q[$];
    q.push_back(mk(1, COMM_BRANCH, 1, 1, 0, 0, O_R | O_N));
    for (int i = 0; i < 3; i++) q.push_back(mk(1, COMM_INT_RF, 0, 1, 0, 0, O_FL));
    q.push_back(mk(1, COMM_INT_RF, 0, 1, 0, 0, O_R | O_INT | O_N));
    q.push_back(mk(1, COMM_BRANCH, 0, 1, 0, 0, O_R | O_N));
    q.push_back(mk(1, COMM_INT_RF, 0, 1, 0, 0, O_R | O_INT | O_N));
    q.push_back(mk(1, COMM_JUMP,   1, 1, 0, 0, O_R | O_INT | O_N));
    for (int i = 0; i < 3; i++) q.push_back(mk(0, COMM_NONE, 0, 1, 0, 0, O_FL));
    q.push_back(mk(1, COMM_JUMP,   0, 1, 0, 0, O_R | O_INT | O_N));
    q.push_back(mk(0, COMM_NONE,   0, 1, 0, 0, 10'h0));
    foreach (q[i]) begin
      apply(q[i]);
      @(negedge clk_i);
      checks++;
      if (outs() !== q[i].exp) begin
        errors++;
        $display("FAIL branch[%0d]: outs=%b required %b", i, outs(), q[i].exp);
      end
      @(posedge clk_i); #1;
    end
  endtask

  task automatic test_csr();
    vec_t q[$];
    q.push_back(mk(1, COMM_CSR, 0, 1, 0, 0, 10'h0, CSR_OP_CSRRW));
    for (int i = 0; i < 4; i++) q.push_back(mk(1, COMM_CSR, 0, 1, 0, 0, O_CV, CSR_OP_CSRRS));
    q.push_back(mk(1, COMM_CSR, 0, 1, 0, 1, O_CV | O_R | O_INT | O_N, CSR_OP_CSRRS));
    for (int i = 0; i < 3; i++) q.push_back(mk(0, COMM_NONE, 0, 1, 0, 0, O_FL));
    q.push_back(mk(0, COMM_NONE, 0, 1, 0, 0, 10'h0));
    foreach (q[i]) begin
      apply(q[i]);
      @(negedge clk_i);
      checks++;
      if (outs() !== q[i].exp) begin
        errors++;
        $display("FAIL csr[%0d]: outs=%b required %b", i, outs(), q[i].exp);
      end
      if (i >= 1 && i <= 5) begin
        checks++;
        if (csr_req_op_o !== CSR_OP_CSRRW) begin
          errors++;
          $display("FAIL csr_op[%0d]: op=%0d required %0d", i, csr_req_op_o, CSR_OP_CSRRW);
        end
      end
      @(posedge clk_i); #1;
    end
  endtask

  task automatic test_fence();
    vec_t q[$];
    for (int i = 0; i < 5; i++) q.push_back(mk(1, COMM_FENCE, 0, 0, 0, 0, 10'h0));
    q.push_back(mk(1, COMM_FENCE, 0, 1, 0, 0, O_R | O_N));
    for (int i = 0; i < 3; i++) q.push_back(mk(0, COMM_NONE, 0, 1, 0, 0, O_FL));
    q.push_back(mk(1, COMM_FENCE, 0, 1, 0, 0, O_R | O_N));
    for (int i = 0; i < 3; i++) q.push_back(mk(0, COMM_NONE, 0, 1, 0, 0, O_FL));
    q.push_back(mk(0, COMM_NONE, 0, 1, 0, 0, 10'h0));
    foreach (q[i]) begin
      apply(q[i]);
      @(negedge clk_i);
      checks++;
      if (outs() !== q[i].exp) begin
        errors++;
        $display("FAIL fence[%0d]: outs=%b required %b", i, outs(), q[i].exp);
      end
      @(posedge clk_i); #1;
    end
  endtask

  task automatic test_except();
    vec_t q[$];
    comm_type_t unk;
    unk = comm_type_t'(5'd20);
    q.push_back(mk(1, COMM_EXCEPT, 0, 1, 0, 0, O_R | O_T));
    for (int i = 0; i < 3; i++) q.push_back(mk(0, COMM_NONE, 0, 1, 0, 0, O_FL));
    q.push_back(mk(1, COMM_ECALL, 0, 1, 0, 0, O_R | O_T));
    for (int i = 0; i < 3; i++) q.push_back(mk(0, COMM_NONE, 0, 1, 0, 0, O_FL));
    q.push_back(mk(1, unk, 0, 1, 0, 0, O_R | O_T));
    for (int i = 0; i < 3; i++) q.push_back(mk(0, COMM_NONE, 0, 1, 0, 0, O_FL));
    q.push_back(mk(1, COMM_MRET, 0, 1, 0, 0, O_R | O_M | O_N));
    for (int i = 0; i < 3; i++) q.push_back(mk(0, COMM_NONE, 0, 1, 0, 0, O_FL));
    q.push_back(mk(0, COMM_NONE, 0, 1, 0, 0, 10'h0));
    foreach (q[i]) begin
      apply(q[i]);
      @(negedge clk_i);
      checks++;
      if (outs() !== q[i].exp) begin
        errors++;
        $display("FAIL except[%0d]: outs=%b required %b", i, outs(), q[i].exp);
      end
      @(posedge clk_i); #1;
    end
  endtask

  task automatic test_wfi();
    vec_t q[$];
    q.push_back(mk(0, COMM_NONE,   0, 1, 0, 0, 10'h0, CSR_OP_NONE, 1, 10'h0));
    q.push_back(mk(1, COMM_WFI,    0, 1, 0, 0, O_R | O_N, CSR_OP_NONE, 1, O_R | O_N));
    q.push_back(mk(1, COMM_INT_RF, 0, 1, 0, 0, 10'h0, CSR_OP_NONE, 1, O_R | O_INT | O_N));
    q.push_back(mk(1, COMM_INT_RF, 0, 1, 0, 0, 10'h0));
    q.push_back(mk(1, COMM_INT_RF, 0, 1, 1, 0, 10'h0));
    q.push_back(mk(1, COMM_INT_RF, 0, 1, 1, 0, O_R | O_INT | O_N));
    q.push_back(mk(0, COMM_NONE,   0, 1, 0, 0, 10'h0));
    q.push_back(mk(1, COMM_WFI,    0, 1, 1, 0, O_R | O_N));
    q.push_back(mk(1, COMM_INT_RF, 0, 1, 0, 0, O_R | O_INT | O_N));
    q.push_back(mk(0, COMM_NONE,   0, 1, 0, 0, 10'h0));
    foreach (q[i]) begin
      apply(q[i]);
      @(negedge clk_i);
      checks++;
      if (outs() !== q[i].exp) begin
        errors++;
        $display("FAIL wfi[%0d]: outs=%b required %b", i, outs(), q[i].exp);
      end
      if (q[i].chk_b) begin
        checks++;
        if (outs_b() !== q[i].exp_b) begin
          errors++;
          $display("FAIL wfi_disabled[%0d]: outs=%b required %b", i, outs_b(), q[i].exp_b);
        end
      end
      @(posedge clk_i); #1;
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_branch();
    test_csr();
    test_fence();
    test_except();
    test_wfi();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
